nixie_scan_ctrl: RTL and testbench
==================================

NIXIE_SCAN_CTRL -- requirements
Module: nixie_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles each digit stays lit; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port rate_set  input  7  binary value to display, 0..127.
REQ-005 SHALL have port load  input  1  single-cycle strobe that requests capture of rate_set.
REQ-006 SHALL have port dataout  output  8  segment code, active-low, bit7=a .. bit1=g, bit0=dp.
REQ-007 SHALL have port dig_sel  output  3  digit enable, active-low one-hot; bit0=units, bit1=tens, bit2=hundreds.
REQ-008 SHALL have port busy  output  1  high while a conversion is in progress.

Function
REQ-009 SHALL use a three-state FSM: IDLE, CONV_H, CONV_T (CONV_U is folded into the commit cycle, see REQ-012).
REQ-010 SHALL sample load only in IDLE; load=1 in IDLE captures rate_set into a 7-bit remainder register, clears the h and t counters and enters CONV_H.
REQ-011 SHALL, in CONV_H: if remainder>=100, subtract 100 and increment h; otherwise enter CONV_T.
REQ-012 SHALL, in CONV_T: if remainder>=10, subtract 10 and increment t; otherwise commit {h, t, remainder} to the display-digit registers and return to IDLE.
REQ-013 SHALL assert busy in every cycle the FSM is not in IDLE; busy duration SHALL equal h+t+2 cycles (0 -> 2 cycles, 127 -> 5 cycles).
REQ-014 SHALL change the display digits only at the commit edge; the scan SHALL show the previous value until then.
REQ-015 SHALL ignore load while busy=1; the strobe is dropped, not queued.
REQ-016 SHALL run a 16-bit prescaler counting 0..SCAN_DIV-1 and wrapping to 0.
REQ-017 SHALL advance the digit index 0->1->2->0 on the cycle the prescaler wraps.
REQ-018 SHALL keep the scan running independently of the FSM; a conversion SHALL NOT reset the prescaler or the index.
REQ-019 SHALL drive dig_sel from the index: index 0 -> 3'b110, 1 -> 3'b101, 2 -> 3'b011.
REQ-020 SHALL drive dataout as a combinational decode of the digit at the current index.
REQ-021 SHALL use these codes: 0=0000_0011, 1=1001_1111, 2=0010_0101, 3=0000_1101, 4=1001_1001, 5=0100_1001, 6=0100_0001, 7=0001_1111, 8=0000_0001, 9=0000_1001, blank=1111_1111.
REQ-022 SHALL never assert more than one dig_sel bit low in any cycle.

Reset
REQ-023 SHALL, with rst=1 at an edge and regardless of state, return the FSM to IDLE.
REQ-024 SHALL, on reset, clear to 0: prescaler, index, remainder, h, t and all display digits.
REQ-025 SHALL, in the cycle after reset, output busy=0, dig_sel=3'b110 and dataout=0000_0011.
REQ-026 SHALL abort a conversion in progress on reset; nothing is committed.

Configuration
REQ-027 SHALL provide leading-zero blanking when macro NIXIE_LZB_EN is defined:
- hundreds digit blank when h=0;
- tens digit blank when h=0 and t=0;
- units digit always shown.
REQ-028 SHALL display all three digits with no blanking when NIXIE_LZB_EN is undefined.

Structure
REQ-029 SHALL place the following in shared package nixie_pkg:
- segment constants SEG_0..SEG_9 and SEG_BLANK;
- the FSM state typedef;
- constant NUM_DIGITS=3.
REQ-030 SHALL instantiate one sub-module, nixie_seg_dec: 4-bit digit in, 8-bit code out, inputs 10..15 -> SEG_BLANK.

Verification
REQ-031 SHALL cover reset: rst for 2 cycles -> busy=0, dig_sel=110, dataout=0000_0011.
REQ-032 SHALL cover a full value: load with rate_set=127 -> busy high for 5 cycles; scan then shows 1001_1111@011, 0010_0101@101, 0001_1111@110.
REQ-033 SHALL cover zero: load with rate_set=0 -> busy high for 2 cycles.
- NIXIE_LZB_EN defined: hundreds and tens show 1111_1111, units shows 0000_0011.
- NIXIE_LZB_EN undefined: all three digits show 0000_0011.
REQ-034 SHALL cover a dropped load: load 50, then load 90 two cycles later -> second load ignored; display 0/5/0 (blank/5/0 with NIXIE_LZB_EN).
REQ-035 SHALL cover scan wrap with SCAN_DIV=4 -> index changes every 4 cycles in the order 0,1,2,0, with exactly one dig_sel bit low at all times.
REQ-036 SHALL cover reset mid-conversion: load 127, assert rst in the 2nd busy cycle -> next cycle busy=0 and all digits 0.

Source files
------------

// File: rtl/nixie_pkg.sv
// Shared constants for the nixie scan controller: segment codes, FSM states, digit count.
// Segment codes are active-low, bit7=a .. bit1=g, bit0=dp.
package nixie_pkg;
  localparam int NUM_DIGITS = 3;

  localparam logic [7:0] SEG_0     = 8'b0000_0011;
  localparam logic [7:0] SEG_1     = 8'b1001_1111;
  localparam logic [7:0] SEG_2     = 8'b0010_0101;
  localparam logic [7:0] SEG_3     = 8'b0000_1101;
  localparam logic [7:0] SEG_4     = 8'b1001_1001;
  localparam logic [7:0] SEG_5     = 8'b0100_1001;
  localparam logic [7:0] SEG_6     = 8'b0100_0001;
  localparam logic [7:0] SEG_7     = 8'b0001_1111;
  localparam logic [7:0] SEG_8     = 8'b0000_0001;
  localparam logic [7:0] SEG_9     = 8'b0000_1001;
  localparam logic [7:0] SEG_BLANK = 8'b1111_1111;

  typedef enum logic [1:0] {IDLE, CONV_H, CONV_T} state_t;
endpackage

// File: rtl/nixie_seg_dec.sv
// BCD digit to active-low segment code; codes 10..15 decode to blank.
module nixie_seg_dec
  import nixie_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [7:0] o_seg
);
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/nixie_scan_ctrl.sv
// Binary-to-BCD converter (repeated subtraction) feeding a 3-digit multiplexed scan.
// Define NIXIE_LZB_EN to blank leading zeros on the hundreds and tens digits.
module nixie_scan_ctrl
  import nixie_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] rate_set,
  input  logic       load,
  output logic [7:0] dataout,
  output logic [2:0] dig_sel,
  output logic       busy
);
  state_t      r_state, w_state_nxt;
  logic [6:0]  r_rem;
  logic [3:0]  r_h, r_t;
  logic [3:0]  r_dig_h, r_dig_t, r_dig_u;
  logic [15:0] r_pres;
  logic [1:0]  r_idx;
  logic        w_wrap;
  logic [3:0]  w_digit;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (load) w_state_nxt = CONV_H;
      CONV_H:  if (r_rem < 7'd100) w_state_nxt = CONV_T;
      CONV_T:  if (r_rem < 7'd10)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);

  // The display registers update only on the commit cycle, so the scan keeps
  // showing the previous value for the whole conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem   <= '0;
      r_h     <= '0;
      r_t     <= '0;
      r_dig_h <= '0;
      r_dig_t <= '0;
      r_dig_u <= '0;
    end else begin
      case (r_state)
        IDLE: if (load) begin
          r_rem <= rate_set;
          r_h   <= '0;
          r_t   <= '0;
        end
        CONV_H: if (r_rem >= 7'd100) begin
          r_rem <= r_rem - 7'd100;
          r_h   <= r_h + 4'd1;
        end
        CONV_T: if (r_rem >= 7'd10) begin
          r_rem <= r_rem - 7'd10;
          r_t   <= r_t + 4'd1;
        end else begin
          r_dig_h <= r_h;
          r_dig_t <= r_t;
          r_dig_u <= r_rem[3:0];
        end
        default: ;
      endcase
    end
  end

  assign w_wrap = (r_pres == 16'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pres <= '0;
      r_idx  <= '0;
    end else if (w_wrap) begin
      r_pres <= '0;
      r_idx  <= (r_idx == 2'(NUM_DIGITS - 1)) ? 2'd0 : r_idx + 2'd1;
    end else begin
      r_pres <= r_pres + 16'd1;
    end
  end

  // Blanked digits are routed as code 15, which the decoder renders dark.
  always_comb begin
    dig_sel = 3'b110;
    w_digit = r_dig_u;
    case (r_idx)
      2'd1: begin
        dig_sel = 3'b101;
`ifdef NIXIE_LZB_EN
        w_digit = (r_dig_h == 4'd0 && r_dig_t == 4'd0) ? 4'hF : r_dig_t;
`else
        w_digit = r_dig_t;
`endif
      end
      2'd2: begin
        dig_sel = 3'b011;
`ifdef NIXIE_LZB_EN
        w_digit = (r_dig_h == 4'd0) ? 4'hF : r_dig_h;
`else
        w_digit = r_dig_h;
`endif
      end
      default: begin
        dig_sel = 3'b110;
        w_digit = r_dig_u;
      end
    endcase
  end

  nixie_seg_dec u_dec (
    .i_digit (w_digit),
    .o_seg   (dataout)
  );
endmodule

// File: tb/tb_nixie_scan_ctrl.sv
// Directed bench for nixie_scan_ctrl with a short scan period; honours NIXIE_LZB_EN.
module tb_nixie_scan_ctrl;
  localparam logic [7:0] C0 = 8'b0000_0011, C1 = 8'b1001_1111, C2 = 8'b0010_0101;
  localparam logic [7:0] C5 = 8'b0100_1001, C7 = 8'b0001_1111, C8 = 8'b0000_0001;
  localparam logic [7:0] C9 = 8'b0000_1001, CB = 8'b1111_1111;
`ifdef NIXIE_LZB_EN
  localparam logic [7:0] ZB = CB;
`else
  localparam logic [7:0] ZB = C0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] rate_set = '0;
  logic       load = 1'b0;
  logic [7:0] dataout;
  logic [2:0] dig_sel;
  logic       busy;

  int checks = 0;
  int errors = 0;

  nixie_scan_ctrl #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .rate_set(rate_set), .load(load),
    .dataout(dataout), .dig_sel(dig_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] rate;
    int         bcyc;
    logic [7:0] eh, et, eu;
  } vec_t;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Load a value and count the cycles busy stays high (bounded).
  task automatic load_and_wait(input logic [6:0] v, output int n);
    rate_set = v; load = 1'b1;
    tick();
    load = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      tick();
    end
  endtask

  // Walk one full scan rotation and compare the code seen at each digit position.
  task automatic scan_check(input string nm, input logic [7:0] eh, input logic [7:0] et,
                            input logic [7:0] eu);
    logic [7:0] sh, st, su;
    logic       bad_sel;
    sh = 'x; st = 'x; su = 'x; bad_sel = 1'b0;
    for (int i = 0; i < 12; i++) begin
      case (dig_sel)
        3'b011: sh = dataout;
        3'b101: st = dataout;
        3'b110: su = dataout;
        default: bad_sel = 1'b1;
      endcase
      tick();
    end
    chk({nm, "_sel_onehot"}, {31'd0, bad_sel}, 32'd0);
    chk({nm, "_hund"}, {24'd0, sh}, {24'd0, eh});
    chk({nm, "_tens"}, {24'd0, st}, {24'd0, et});
    chk({nm, "_unit"}, {24'd0, su}, {24'd0, eu});
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    vecs[0] = '{7'd127, 5, C1, C2, C7};
    vecs[1] = '{7'd0,   2, ZB, ZB, C0};
    vecs[2] = '{7'd9,   2, ZB, ZB, C9};
    vecs[3] = '{7'd10,  3, ZB, C1, C0};
    vecs[4] = '{7'd100, 3, C1, C0, C0};
    vecs[5] = '{7'd58,  7, ZB, C5, C8};

    // Reset state, then scan ordering with period 4 from the reset edge.
    do_reset();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sel", {29'd0, dig_sel}, {29'd0, 3'b110});
    chk("rst_data", {24'd0, dataout}, {24'd0, C0});
    begin
      logic [2:0] exp_sel;
      int bad;
      bad = 0;
      for (int k = 0; k < 13; k++) begin
        case ((k / 4) % 3)
          0: exp_sel = 3'b110;
          1: exp_sel = 3'b101;
          default: exp_sel = 3'b011;
        endcase
        if (dig_sel !== exp_sel) begin
          bad++;
          $display("FAIL scan_order k=%0d got %b expected %b", k, dig_sel, exp_sel);
        end
        tick();
      end
      chk("scan_order_errs", bad, 0);
    end

    // Table-driven conversions.
    foreach (vecs[i]) begin
      load_and_wait(vecs[i].rate, n);
      chk($sformatf("busy_len_%0d", vecs[i].rate), n, vecs[i].bcyc);
      scan_check($sformatf("val_%0d", vecs[i].rate), vecs[i].eh, vecs[i].et, vecs[i].eu);
    end

    // Load during a conversion is dropped.
    rate_set = 7'd50; load = 1'b1; tick(); load = 1'b0;
    tick();
    rate_set = 7'd90; load = 1'b1; tick(); load = 1'b0;
    n = 0;
    while (busy && n < 20) begin n++; tick(); end
    chk("drop_busy_done", {31'd0, busy}, 32'd0);
    scan_check("drop", ZB, C5, C0);

    // Display holds the old value while converting; reset mid-conversion clears all.
    rate_set = 7'd127; load = 1'b1; tick(); load = 1'b0;
    chk("mid_busy1", {31'd0, busy}, 32'd1);
    tick();
    chk("mid_busy2", {31'd0, busy}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_sel", {29'd0, dig_sel}, {29'd0, 3'b110});
    chk("mid_rst_data", {24'd0, dataout}, {24'd0, C0});
    scan_check("mid_rst", ZB, ZB, C0);
    tick(); tick(); tick();
    chk("mid_no_late_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1);
  end
endmodule
